// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit, splits word-crossing accesses into two word accesses
// Ports: clk, rst (async, active-high); req_* pipeline request with req_ready handshake;
// resp_valid/resp_err/resp_data completion; mem_* word-addressed byte-lane memory port
// (mem_rdata valid the cycle after mem_en).
module lsu_align #(
  parameter int ADDR_W           = 12,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
  state_t state;
  logic we_q;
  logic [2:0] f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wd_q, w0_q, data_q, sh, ld;
  logic [1:0] off;
  logic [2:0] size;
  logic [3:0] mask;
  logic [7:0] be64;
  logic [63:0] wd64, rd64;
  logic [ADDR_W-3:0] word0, word1;
  logic split, illegal, err, acc1, acc2;
  always_comb begin
    off = addr_q[1:0];
    size = f3_q[1:0] == 2'b00 ? 3'd1 : f3_q[1:0] == 2'b01 ? 3'd2 : 3'd4;
    mask = f3_q[1:0] == 2'b00 ? 4'b0001 : f3_q[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    split = {1'b0, off} + size > 3'd4;
    illegal = f3_q[1:0] == 2'b11 || f3_q == 3'b110 || (we_q && f3_q[2]);
    err = illegal || (split && !ALLOW_MISALIGNED);
    word0 = addr_q[ADDR_W-1:2];
    word1 = word0 + (ADDR_W-2)'(1);
    // Both word lanes computed at once: low half goes to word0, high half to word1.
    be64 = {4'b0, mask} << off;
    wd64 = {32'b0, wd_q & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}}} << {off, 3'b0};
    // The last access's read word arrives during RESP; word0 of a split was captured in ACC2.
    rd64 = split ? {mem_rdata, w0_q} : {32'b0, mem_rdata};
    sh = rd64[{off, 3'b0} +: 32];
    ld = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
         f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
         f3_q == 3'b100 ? {24'b0, sh[7:0]} :
         f3_q == 3'b101 ? {16'b0, sh[15:0]} : sh;
    acc1 = state == ACC1 && !err;
    acc2 = state == ACC2;
    mem_en = acc1 || acc2;
    mem_we = mem_en && we_q;
    mem_addr = acc1 ? word0 : acc2 ? word1 : '0;
    mem_be = !mem_en ? 4'b0 : !we_q ? 4'hf : acc2 ? be64[7:4] : be64[3:0];
    mem_wdata = !mem_we ? 32'b0 : acc2 ? wd64[63:32] : wd64[31:0];
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    // Load data is formed live in RESP and then held in data_q until the next response.
    resp_data = state == RESP ? ((we_q || resp_err) ? 32'b0 : ld) : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= 3'b0;
      addr_q <= '0;
      wd_q <= 32'b0;
      w0_q <= 32'b0;
      data_q <= 32'b0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          f3_q <= req_funct3;
          addr_q <= req_addr;
          wd_q <= req_wdata;
          state <= ACC1;
        end
        ACC1: begin
          state <= (err || !split) ? RESP : ACC2;
          if (err || !split) resp_err <= err;
        end
        ACC2: begin
          w0_q <= mem_rdata;
          resp_err <= 1'b0;
          state <= RESP;
        end
        default: begin
          data_q <= resp_data;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: scoreboard bench for lsu_align, one instance with and one without misaligned splitting
module tb_lsu_align;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = 3'b0;
  logic [11:0] req_addr = 12'b0;
  logic [31:0] req_wdata = 32'b0;
  logic rdy1, rv1, re1, en1, we1, rdy0, rv0, re0, en0, we0;
  logic [31:0] rd1, rd0, wd1, wd0, mr1, mr0;
  logic [9:0] ma1, ma0;
  logic [3:0] be1, be0;
  logic [31:0] m1 [0:1023];
  logic [31:0] m0 [0:1023];
  int checks = 0, failures = 0, cyc = 0;
  typedef struct { int cyc; logic [9:0] a; logic we; logic [3:0] be; logic [31:0] wd; } acc_t;
  typedef struct { int cyc; logic [31:0] d; logic e; } rsp_t;
  acc_t aq1 [$], aq0 [$], xa1, xa0;
  rsp_t rq1 [$], rq0 [$], xr1, xr0;

  lsu_align #(.ADDR_W(12), .ALLOW_MISALIGNED(1'b1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_err(re1), .resp_data(rd1), .mem_en(en1), .mem_we(we1),
    .mem_addr(ma1), .mem_be(be1), .mem_wdata(wd1), .mem_rdata(mr1));
  lsu_align #(.ADDR_W(12), .ALLOW_MISALIGNED(1'b0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_err(re0), .resp_data(rd0), .mem_en(en0), .mem_we(we0),
    .mem_addr(ma0), .mem_be(be0), .mem_wdata(wd0), .mem_rdata(mr0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (en1) begin
    if (we1) for (int i = 0; i < 4; i++) if (be1[i]) m1[ma1][8*i +: 8] <= wd1[8*i +: 8];
    mr1 <= m1[ma1];
  end
  always @(posedge clk) if (en0) begin
    if (we0) for (int i = 0; i < 4; i++) if (be0[i]) m0[ma0][8*i +: 8] <= wd0[8*i +: 8];
    mr0 <= m0[ma0];
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Expected memory access `rel` cycles after the accept edge; both=0 means only the splitting instance.
  task automatic acc(input bit both, input int rel, input logic [9:0] a, input logic we,
                     input logic [3:0] be, input logic [31:0] wd);
    acc_t x;
    x = '{cyc + rel, a, we, be, wd};
    aq1.push_back(x);
    if (both) aq0.push_back(x);
  endtask

  task automatic rsp(input int l1, input logic [31:0] d1, input logic e1,
                     input int l0, input logic [31:0] d0, input logic e0);
    rq1.push_back('{cyc + l1, d1, e1});
    rq0.push_back('{cyc + l0, d0, e0});
  endtask

  // Holds req_valid through the busy cycles with scrambled fields to show they are ignored.
  task automatic send(input logic we, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
    repeat (2) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    for (int i = 0; i < 8 && !(rdy1 && rdy0); i++) begin @(posedge clk); #1; end
    if (!(rdy1 && rdy0)) chk("ready_timeout", {30'b0, rdy1, rdy0}, 32'h3);
  endtask

  always @(negedge clk) begin
    if (en1) begin
      if (aq1.size() == 0) chk("acc1_unexpected", 32'(en1), 32'h0);
      else begin
        xa1 = aq1.pop_front();
        chk("acc1_cyc", cyc, xa1.cyc);
        chk("acc1_addr", 32'(ma1), 32'(xa1.a));
        chk("acc1_we", 32'(we1), 32'(xa1.we));
        chk("acc1_be", 32'(be1), 32'(xa1.be));
        chk("acc1_wdata", wd1, xa1.wd);
      end
    end
    if (en0) begin
      if (aq0.size() == 0) chk("acc0_unexpected", 32'(en0), 32'h0);
      else begin
        xa0 = aq0.pop_front();
        chk("acc0_cyc", cyc, xa0.cyc);
        chk("acc0_addr", 32'(ma0), 32'(xa0.a));
        chk("acc0_we", 32'(we0), 32'(xa0.we));
        chk("acc0_be", 32'(be0), 32'(xa0.be));
        chk("acc0_wdata", wd0, xa0.wd);
      end
    end
    if (rv1) begin
      if (rq1.size() == 0) chk("rsp1_unexpected", 32'(rv1), 32'h0);
      else begin
        xr1 = rq1.pop_front();
        chk("rsp1_cyc", cyc, xr1.cyc);
        chk("rsp1_data", rd1, xr1.d);
        chk("rsp1_err", 32'(re1), 32'(xr1.e));
      end
    end
    if (rv0) begin
      if (rq0.size() == 0) chk("rsp0_unexpected", 32'(rv0), 32'h0);
      else begin
        xr0 = rq0.pop_front();
        chk("rsp0_cyc", cyc, xr0.cyc);
        chk("rsp0_data", rd0, xr0.d);
        chk("rsp0_err", 32'(re0), 32'(xr0.e));
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin m1[i] = 32'b0; m0[i] = 32'b0; end
    m1[0] = 32'h11223344;     m0[0] = 32'h11223344;
    m1[1] = 32'h80112233;     m0[1] = 32'h80112233;
    m1[16] = 32'hCC000000;    m0[16] = 32'hCC000000;
    m1[17] = 32'h000000AB;    m0[17] = 32'h000000AB;
    m1[1023] = 32'h55667788;  m0[1023] = 32'h55667788;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {30'b0, rdy1, rdy0}, 32'h3);
    chk("rst_resp", {29'b0, rv1, re1, rv0}, 32'h0);
    chk("rst_data", rd1 | rd0, 32'h0);
    chk("rst_mem", {26'b0, en1, we1, be1}, 32'h0);
    chk("rst_addr", {22'b0, ma1}, 32'h0);
    chk("rst_wdata", wd1, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    acc(1, 1, 10'h2, 1, 4'hf, 32'hAABBCCDD); rsp(2, 0, 0, 2, 0, 0);
    send(1, 3'b010, 12'h008, 32'hAABBCCDD);
    acc(1, 1, 10'h3, 1, 4'b0010, 32'h0000EF00); rsp(2, 0, 0, 2, 0, 0);
    send(1, 3'b000, 12'h00D, 32'h000000EF);
    acc(1, 1, 10'h3, 1, 4'b1100, 32'h12340000); rsp(2, 0, 0, 2, 0, 0);
    send(1, 3'b001, 12'h00E, 32'hDEAD1234);
    acc(1, 1, 10'h3, 0, 4'hf, 0); rsp(2, 32'h1234EF00, 0, 2, 32'h1234EF00, 0);
    send(0, 3'b010, 12'h00C, 0);
    acc(1, 1, 10'h1, 0, 4'hf, 0); rsp(2, 32'hFFFFFF80, 0, 2, 32'hFFFFFF80, 0);
    send(0, 3'b000, 12'h007, 0);
    acc(1, 1, 10'h1, 0, 4'hf, 0); rsp(2, 32'h00000080, 0, 2, 32'h00000080, 0);
    send(0, 3'b100, 12'h007, 0);
    acc(1, 1, 10'h0, 0, 4'hf, 0); rsp(2, 32'h00002233, 0, 2, 32'h00002233, 0);
    send(0, 3'b101, 12'h001, 0);
    acc(0, 1, 10'h10, 0, 4'hf, 0); acc(0, 2, 10'h11, 0, 4'hf, 0); rsp(3, 32'hFFFFABCC, 0, 2, 0, 1);
    send(0, 3'b001, 12'h043, 0);
    acc(0, 1, 10'h1, 1, 4'b1100, 32'hCCDD0000); acc(0, 2, 10'h2, 1, 4'b0011, 32'h0000AABB);
    rsp(3, 0, 0, 2, 0, 1);
    send(1, 3'b010, 12'h006, 32'hAABBCCDD);
    acc(0, 1, 10'h1, 0, 4'hf, 0); acc(0, 2, 10'h2, 0, 4'hf, 0); rsp(3, 32'hAABBCCDD, 0, 2, 0, 1);
    send(0, 3'b010, 12'h006, 0);
    acc(0, 1, 10'h1, 0, 4'hf, 0); acc(0, 2, 10'h2, 0, 4'hf, 0); rsp(3, 32'hFFFFBBCC, 0, 2, 0, 1);
    send(0, 3'b001, 12'h007, 0);
    acc(0, 1, 10'h3FF, 0, 4'hf, 0); acc(0, 2, 10'h0, 0, 4'hf, 0); rsp(3, 32'h33445566, 0, 2, 0, 1);
    send(0, 3'b010, 12'hFFE, 0);
    rsp(2, 0, 1, 2, 0, 1);
    send(0, 3'b011, 12'h000, 0);
    rsp(2, 0, 1, 2, 0, 1);
    send(1, 3'b100, 12'h004, 32'h12345678);
    acc(1, 1, 10'h3FF, 0, 4'hf, 0); rsp(2, 32'h55667788, 0, 2, 32'h55667788, 0);
    send(0, 3'b010, 12'hFFC, 0);
    acc(0, 1, 10'h40, 1, 4'b1100, 32'h03040000);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 12'h102; req_wdata = 32'h01020304;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("acc2_en_before_rst", 32'(en1), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_en", 32'(en1), 32'h0);
    chk("rst_no_resp", {30'b0, rv1, rv0}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_ready_after", {30'b0, rdy1, rdy0}, 32'h3);
    repeat (2) begin @(posedge clk); #1; end
    acc(1, 1, 10'h2, 0, 4'hf, 0); rsp(2, 32'hAABBAABB, 0, 2, 32'hAABBCCDD, 0);
    send(0, 3'b010, 12'h008, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("acc_queue_left", aq1.size() + aq0.size(), 0);
    chk("rsp_queue_left", rq1.size() + rq0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
